// File: rtl/pkt_pkg.sv
// Shared definitions for the packet writer and the register bank.
// Holds the capture state encoding (mirrored into the control register LSBs),
// the control register enable bit index and the word-size helper constant.
package pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_DRAIN   = 2'b10,
        ST_FULL    = 2'b11
    } state_t;

    // Bit of the control register that carries the capture enable.
    localparam int CTRL_ENABLE_BIT = 2;

    // Default bus width and the byte stride of one bus word.
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = DATA_W / 8;

endpackage

// File: rtl/avalon_pkt_writer_slot.sv
// avalon_wr_slot: single-entry Avalon-MM write request holder.
// A loaded request is presented on m_write/m_address/m_writedata and held
// stable while m_waitrequest is high. A new load in the cycle the current
// request completes replaces it without a bubble.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture a new request this cycle
//   load_address/data   address and data of the new request
//   load_eop            new request carries the last word of a packet
//   m_waitrequest       slave stall
//   m_write/m_address/m_writedata  registered Avalon request
//   slot_eop            presented request carries an eop word
//   done                presented request completes this cycle
module avalon_wr_slot #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_address,
    input  logic [N-1:0] load_data,
    input  logic         load_eop,
    input  logic         m_waitrequest,
    output logic         m_write,
    output logic [N-1:0] m_address,
    output logic [N-1:0] m_writedata,
    output logic         slot_eop,
    output logic         done
);

    assign done = m_write & ~m_waitrequest;

    // Request register: load wins, otherwise clear on completion, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_write     <= 1'b0;
            m_address   <= {N{1'b0}};
            m_writedata <= {N{1'b0}};
            slot_eop    <= 1'b0;
        end else if (load) begin
            m_write     <= 1'b1;
            m_address   <= load_address;
            m_writedata <= load_data;
            slot_eop    <= load_eop;
        end else if (done) begin
            m_write  <= 1'b0;
            slot_eop <= 1'b0;
        end
    end

endmodule

// File: rtl/avalon_pkt_writer.sv
// avalon_pkt_writer: Avalon-MM write master storing captured packet words
// into a ring buffer window [pkt_begin, pkt_end) in SDRAM.
// Words before the first sop after a start are discarded; packet words are
// written one per cycle when the slave does not stall.
// Optional feature macro: PKT_WRITER_WRAP_EN
//   defined   - the write pointer wraps to the window start at the end
//   undefined - reaching the window end stops capture in FULL/ERROR and
//               back-pressures the stream
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   enable                  capture enable
//   pkt_begin, pkt_end      window byte addresses (sampled at start)
//   s_data/s_valid/s_sop/s_eop/s_ready   packet stream input
//   m_address/m_write/m_writedata/m_waitrequest  Avalon-MM write master
//   state                   00 IDLE, 01 CAPTURE, 10 DRAIN, 11 FULL/ERROR
//   wr_ptr                  next byte address to be written
//   pkt_count               completed packets (wraps)
module avalon_pkt_writer
    import pkt_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     pkt_begin,
    input  logic [N-1:0]     pkt_end,
    input  logic [N-1:0]     s_data,
    input  logic             s_valid,
    input  logic             s_sop,
    input  logic             s_eop,
    output logic             s_ready,
    output logic [N-1:0]     m_address,
    output logic             m_write,
    output logic [N-1:0]     m_writedata,
    input  logic             m_waitrequest,
    output logic [1:0]       state,
    output logic [N-1:0]     wr_ptr,
    output logic [CNT_W-1:0] pkt_count
);

    localparam logic [N-1:0] STEP       = N'(N / 8);
    localparam logic [N-1:0] ALIGN_MASK = STEP - {{(N-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nx_s;
    logic             in_pkt_r;
    logic             full_pend_r;
    logic [N-1:0]     wr_ptr_r;
    logic [N-1:0]     end_r;
    logic [CNT_W-1:0] pkt_count_r;
`ifdef PKT_WRITER_WRAP_EN
    logic [N-1:0]     begin_r;
`endif

    logic             can_take_s;
    logic             accept_s;
    logic             issue_s;
    logic             pending_s;
    logic             done_s;
    logic             slot_eop_s;
    logic             win_ok_s;
    logic             hit_end_s;
    logic [N-1:0]     adv_s;
    logic [N-1:0]     ptr_nx_s;

    assign win_ok_s  = (pkt_begin < pkt_end) &&
                       ((pkt_begin & ALIGN_MASK) == {N{1'b0}}) &&
                       ((pkt_end & ALIGN_MASK) == {N{1'b0}});
    assign adv_s     = wr_ptr_r + STEP;
    assign hit_end_s = (adv_s == end_r);
`ifdef PKT_WRITER_WRAP_EN
    assign ptr_nx_s  = hit_end_s ? begin_r : adv_s;
`else
    assign ptr_nx_s  = adv_s;
`endif

    // A write still occupies the slot next cycle only if it is stalled now.
    assign pending_s = m_write & m_waitrequest;

    // Which states may take stream words. With enable low in CAPTURE only the
    // open packet continues; DRAIN stops taking words once its packet closed.
    always_comb begin
        can_take_s = 1'b0;
        case (state_r)
            ST_CAPTURE: can_take_s = (enable | in_pkt_r) & ~full_pend_r;
            ST_DRAIN:   can_take_s = in_pkt_r & ~full_pend_r;
            default:    can_take_s = 1'b0;
        endcase
    end

    assign s_ready  = can_take_s & (~m_write | ~m_waitrequest);
    assign accept_s = s_valid & s_ready;
    assign issue_s  = accept_s & (in_pkt_r | s_sop);

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nx_s = win_ok_s ? ST_CAPTURE : ST_FULL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (full_pend_r && !pending_s) begin
                    state_nx_s = ST_FULL;
                end else if (!enable && in_pkt_r) begin
                    state_nx_s = ST_DRAIN;
                end else if (!enable && !pending_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (full_pend_r && !pending_s) begin
                    state_nx_s = ST_FULL;
                end else if (enable) begin
                    state_nx_s = ST_CAPTURE;
                end else if (done_s && slot_eop_s) begin
                    state_nx_s = ST_IDLE;
                end else if (!in_pkt_r && !m_write) begin
                    // Packet already closed and nothing in flight.
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_FULL: begin
                if (!enable && !pending_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, window sampling, write pointer, framing and packet counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_pkt_r    <= 1'b0;
            full_pend_r <= 1'b0;
            wr_ptr_r    <= {N{1'b0}};
            end_r       <= {N{1'b0}};
            pkt_count_r <= {CNT_W{1'b0}};
`ifdef PKT_WRITER_WRAP_EN
            begin_r     <= {N{1'b0}};
`endif
        end else begin
            state_r <= state_nx_s;
            if ((state_r == ST_IDLE) && (state_nx_s == ST_CAPTURE)) begin
                wr_ptr_r    <= pkt_begin;
                end_r       <= pkt_end;
                in_pkt_r    <= 1'b0;
                full_pend_r <= 1'b0;
`ifdef PKT_WRITER_WRAP_EN
                begin_r     <= pkt_begin;
`endif
            end else begin
                if (accept_s) begin
                    in_pkt_r <= (in_pkt_r | s_sop) & ~s_eop;
                end
                if (issue_s) begin
                    wr_ptr_r <= ptr_nx_s;
`ifdef PKT_WRITER_WRAP_EN
                    full_pend_r <= 1'b0;
`else
                    full_pend_r <= hit_end_s;
`endif
                end
            end
            if (done_s && slot_eop_s) begin
                pkt_count_r <= pkt_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    avalon_wr_slot #(.N(N)) u_slot (
        .clk          (clk),
        .reset        (reset),
        .load         (issue_s),
        .load_address (wr_ptr_r),
        .load_data    (s_data),
        .load_eop     (s_eop),
        .m_waitrequest(m_waitrequest),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .slot_eop     (slot_eop_s),
        .done         (done_s)
    );

    assign state     = state_r;
    assign wr_ptr    = wr_ptr_r;
    assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_avalon_pkt_writer.sv
`timescale 1ns/1ps
module tb_avalon_pkt_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] pkt_begin = 32'h0;
    logic [31:0] pkt_end = 32'h0;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_sop = 1'b0;
    logic        s_eop = 1'b0;
    logic        s_ready;
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic [1:0]  state;
    logic [31:0] wr_ptr;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    avalon_pkt_writer #(.N(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pkt_begin(pkt_begin), .pkt_end(pkt_end),
        .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
        .s_ready(s_ready),
        .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest),
        .state(state), .wr_ptr(wr_ptr), .pkt_count(pkt_count)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        eop;
    } wr_t;

    wr_t         exp_q[$];
    int          done_cyc_q[$];
    logic [31:0] done_addr_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          auto_wr = 1'b0;

    // Reference model: window, next address, packet framing, packet count.
    logic [31:0] mdl_ptr, mdl_begin, mdl_end;
    bit          mdl_in_pkt = 1'b0;
    int          mdl_cnt = 0;

    bit          hold_prev = 1'b0;
    logic [31:0] hold_addr, hold_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void mdl_accept(input logic [31:0] d, input bit sop, input bit eop);
        if (mdl_in_pkt || sop) begin
            exp_q.push_back({mdl_ptr, d, eop});
            mdl_ptr = mdl_ptr + 32'd4;
`ifdef PKT_WRITER_WRAP_EN
            if (mdl_ptr == mdl_end) mdl_ptr = mdl_begin;
`endif
        end
        mdl_in_pkt = (mdl_in_pkt || sop) && !eop;
    endfunction

    // Random slave stalls when enabled.
    always @(posedge clk) begin
        #1;
        if (auto_wr) m_waitrequest = ($urandom_range(0, 3) == 0);
    end

    // Monitor: protocol checks and scoreboard pop on each completed write.
    always @(negedge clk) begin
        if (!reset) begin
            if (hold_prev) begin
                chk("hold_write", {63'd0, m_write}, 64'd1);
                chk("hold_addr", {32'd0, m_address}, {32'd0, hold_addr});
                chk("hold_data", {32'd0, m_writedata}, {32'd0, hold_data});
            end
            if (m_write && m_waitrequest) chk("ready_low_in_stall", {63'd0, s_ready}, 64'd0);
            hold_prev = m_write && m_waitrequest;
            hold_addr = m_address;
            hold_data = m_writedata;
            if (m_write && !m_waitrequest) begin
                done_cyc_q.push_back(cyc);
                done_addr_q.push_back(m_address);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: actual addr=%0h data=%0h required none", m_address, m_writedata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", {32'd0, m_address}, {32'd0, e.addr});
                    chk("write_data", {32'd0, m_writedata}, {32'd0, e.data});
                    if (e.eop) mdl_cnt++;
                end
            end
        end else begin
            hold_prev = 1'b0;
        end
        cyc++;
    end

    task automatic send(input logic [31:0] d, input bit sop, input bit eop, input int budget,
                        output bit acc, output int waited);
        s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
        acc = 1'b0; waited = 0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (s_ready) begin
                mdl_accept(d, sop, eop);
                acc = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic put(input logic [31:0] d, input bit sop, input bit eop);
        bit acc;
        int w;
        send(d, sop, eop, 200, acc, w);
        chk("word_accepted", {63'd0, acc}, 64'd1);
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] e);
        pkt_begin = b; pkt_end = e; enable = 1'b1;
        mdl_begin = b; mdl_end = e; mdl_ptr = b; mdl_in_pkt = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int budget, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (state == tgt) hit = 1'b1;
        end
        @(posedge clk); #1;
        chk(nm, {62'd0, state}, {62'd0, tgt});
    endtask

    task automatic stop();
        s_valid = 1'b0;
        enable = 1'b0;
        wait_state(2'b00, 200, "stop_idle");
        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("pkt_count", {48'd0, pkt_count}, {48'd0, mdl_cnt[15:0]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int w;
        int nd;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {62'd0, state}, 64'd0);
        chk("rst_m_write", {63'd0, m_write}, 64'd0);
        chk("rst_m_address", {32'd0, m_address}, 64'd0);
        chk("rst_m_writedata", {32'd0, m_writedata}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_wr_ptr", {32'd0, wr_ptr}, 64'd0);
        chk("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: four-word packet, no stalls, window of exactly four words.
        done_cyc_q.delete();
        start(32'h1000, 32'h1010);
        put(32'hA0A0_0001, 1'b1, 1'b0);
        put(32'hA0A0_0002, 1'b0, 1'b0);
        put(32'hA0A0_0003, 1'b0, 1'b0);
        put(32'hA0A0_0004, 1'b0, 1'b1);
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t1_write_count", 64'(done_cyc_q.size()), 64'd4);
        if (done_cyc_q.size() == 4)
            chk("t1_consecutive", 64'(done_cyc_q[3] - done_cyc_q[0]), 64'd3);
`ifdef PKT_WRITER_WRAP_EN
        chk("t1_wr_ptr", {32'd0, wr_ptr}, 64'h1000);
        chk("t1_state", {62'd0, state}, 64'd1);
`else
        chk("t1_wr_ptr", {32'd0, wr_ptr}, 64'h1010);
        chk("t1_state", {62'd0, state}, 64'd3);
`endif
        chk("t1_pkt_count", {48'd0, pkt_count}, 64'd1);
        stop();

        // 2: three-cycle stall on word 2.
        start(32'h1100, 32'h1200);
        put(32'hB0B0_0001, 1'b1, 1'b0);
        put(32'hB0B0_0002, 1'b0, 1'b0);
        m_waitrequest = 1'b1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 m_waitrequest = 1'b0;
            end
        join_none
        send(32'hB0B0_0003, 1'b0, 1'b0, 50, acc, w);
        chk("t2_word3_accepted", {63'd0, acc}, 64'd1);
        chk("t2_ready_low_cycles", 64'(w), 64'd3);
        put(32'hB0B0_0004, 1'b0, 1'b1);
        stop();

        // 3: pre-sop words are discarded.
        done_addr_q.delete();
        start(32'h1200, 32'h1300);
        put(32'h0000_DEAD, 1'b0, 1'b0);
        put(32'h0000_BEEF, 1'b0, 1'b0);
        put(32'hC0C0_0001, 1'b1, 1'b0);
        put(32'hC0C0_0002, 1'b0, 1'b1);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_write_count", 64'(done_addr_q.size()), 64'd2);
        if (done_addr_q.size() > 0)
            chk("t3_first_addr", {32'd0, done_addr_q[0]}, 64'h1200);
        stop();

        // 4: enable dropped mid-packet -> DRAIN until eop written.
        start(32'h1300, 32'h1400);
        put(32'hD0D0_0001, 1'b1, 1'b0);
        put(32'hD0D0_0002, 1'b0, 1'b0);
        enable = 1'b0;
        put(32'hD0D0_0003, 1'b0, 1'b0);
        chk("t4_drain", {62'd0, state}, 64'd2);
        put(32'hD0D0_0004, 1'b0, 1'b0);
        put(32'hD0D0_0005, 1'b0, 1'b1);
        s_valid = 1'b0;
        wait_state(2'b00, 50, "t4_idle");
        chk("t4_pkt_count", {48'd0, pkt_count}, 64'd4);
        stop();

        // 5: two-word window, three-word packet.
        done_addr_q.delete();
        start(32'h1400, 32'h1408);
        put(32'hE0E0_0001, 1'b1, 1'b0);
        put(32'hE0E0_0002, 1'b0, 1'b0);
        send(32'hE0E0_0003, 1'b0, 1'b1, 20, acc, w);
        repeat (3) @(posedge clk);
        #1;
`ifdef PKT_WRITER_WRAP_EN
        chk("t5_third_accepted", {63'd0, acc}, 64'd1);
        chk("t5_write_count", 64'(done_addr_q.size()), 64'd3);
        if (done_addr_q.size() == 3)
            chk("t5_wrap_addr", {32'd0, done_addr_q[2]}, 64'h1400);
`else
        chk("t5_third_blocked", {63'd0, acc}, 64'd0);
        chk("t5_write_count", 64'(done_addr_q.size()), 64'd2);
        chk("t5_state_full", {62'd0, state}, 64'd3);
        chk("t5_s_ready", {63'd0, s_ready}, 64'd0);
`endif
        stop();

        // 6: invalid windows go to FULL/ERROR without writing.
        nd = done_cyc_q.size();
        start(32'h2000, 32'h1000);
        @(posedge clk); #1;
        chk("t6_reversed_full", {62'd0, state}, 64'd3);
        s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_s_ready", {63'd0, s_ready}, 64'd0);
        chk("t6_no_writes", 64'(done_cyc_q.size()), 64'(nd));
        s_valid = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
        chk("t6_back_idle", {62'd0, state}, 64'd0);
        start(32'h2002, 32'h3000);
        @(posedge clk); #1;
        chk("t6_misaligned_full", {62'd0, state}, 64'd3);
        stop();

        // Randomized packets with random stalls, gaps and junk words.
        auto_wr = 1'b1;
`ifdef PKT_WRITER_WRAP_EN
        start(32'h4000, 32'h4014);
`else
        start(32'h4000, 32'h4400);
`endif
        for (int p = 0; p < 20; p++) begin
            int len;
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) put($urandom, 1'b0, 1'b0);
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if (k == 1) begin
                    pkt_begin = $urandom;
                    pkt_end = $urandom;
                end
                put($urandom, k == 0, k == len - 1);
            end
        end
        stop();
        auto_wr = 1'b0;
        m_waitrequest = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
